// File: rtl/stream_copier_pkg.sv
// Shared widths and FSM state encoding for the stream copier and its address steppers.
package stream_copier_pkg;

    localparam int ADDRESS_BITS = 8;
    localparam int DATA_BITS    = 8;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRIME  = 3'd1;
    localparam logic [STATE_W-1:0] ST_STREAM = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/stream_copier_address_stepper.sv
// Address register with load and signed stride step; the add truncates, so wrap is modulo 2^addrBits.
module stream_copier_address_stepper #(
    parameter int addrBits = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [addrBits-1:0] load_addr,
    input  logic                step,
    input  logic [addrBits-1:0] stride,
    output logic [addrBits-1:0] addr
);

    logic [addrBits-1:0] addr_q;
    logic [addrBits-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_addr;
        end else if (step) begin
            addr_d = addr_q + stride;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/stream_copier.sv
// Block copy / constant fill between two IceRam ports with start/busy/finished handshake and abort.
// Handshake: start is a one-cycle request honoured only in IDLE or DONE; finished/aborted are levels held until the next accepted start.
module stream_copier
    import stream_copier_pkg::*;
#(
    parameter int addrBits = ADDRESS_BITS,
    parameter int dataBits = DATA_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                fillMode,
    input  logic [addrBits-1:0] startReadAddress,
    input  logic [addrBits-1:0] startWriteAddress,
    input  logic [addrBits-1:0] readStride,
    input  logic [addrBits-1:0] writeStride,
    input  logic [addrBits-1:0] numberOfWordsToCopy,
    input  logic [dataBits-1:0] fillValue,
    input  logic                abort,
    output logic                busy,
    output logic                finished,
    output logic                aborted,
    output logic [addrBits-1:0] readAddress,
    output logic                readReadWriteMode,
    input  logic [dataBits-1:0] readDataOut,
    output logic [addrBits-1:0] writeAddress,
    output logic                writeReadWriteMode,
    output logic [dataBits-1:0] writeDataIn,
    output logic [STATE_W-1:0]  state_dbg
);

    logic [STATE_W-1:0]  state_q, state_d;
    logic [addrBits-1:0] count_q, count_d;
    logic [addrBits-1:0] read_stride_q, read_stride_d;
    logic [addrBits-1:0] write_stride_q, write_stride_d;
    logic [dataBits-1:0] fill_value_q, fill_value_d;
    logic                fill_q, fill_d;
    logic                aborted_q, aborted_d;

    logic rd_load, rd_step, wr_load, wr_step, wr_en;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        read_stride_d  = read_stride_q;
        write_stride_d = write_stride_q;
        fill_value_d   = fill_value_q;
        fill_d         = fill_q;
        aborted_d      = aborted_q;
        rd_load        = 1'b0;
        rd_step        = 1'b0;
        wr_load        = 1'b0;
        wr_step        = 1'b0;
        wr_en          = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    fill_d         = fillMode;
                    fill_value_d   = fillValue;
                    read_stride_d  = readStride;
                    write_stride_d = writeStride;
                    count_d        = numberOfWordsToCopy;
                    aborted_d      = 1'b0;
                    wr_load        = 1'b1;
                    // Fill mode never touches the source port, so its address is left alone.
                    rd_load        = !fillMode && (numberOfWordsToCopy != '0);
                    if (numberOfWordsToCopy == '0) begin
                        state_d = ST_DONE;
                    end else if (fillMode) begin
                        state_d = ST_STREAM;
                    end else begin
                        state_d = ST_PRIME;
                    end
                end
            end

            ST_PRIME: begin
                rd_step = 1'b1;
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (count_q == addrBits'(1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_STREAM;
                end
            end

            ST_STREAM: begin
                wr_en   = 1'b1;
                wr_step = 1'b1;
                rd_step = !fill_q;
                count_d = count_q - addrBits'(1);
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (fill_q && count_q == addrBits'(1)) begin
                    state_d = ST_DONE;
                end else if (!fill_q && count_q == addrBits'(2)) begin
                    // The read for the last word was just issued; one write left.
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                wr_en   = 1'b1;
                wr_step = 1'b1;
                count_d = count_q - addrBits'(1);
                state_d = ST_DONE;
                if (abort) begin
                    aborted_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            read_stride_q  <= '0;
            write_stride_q <= '0;
            fill_value_q   <= '0;
            fill_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            read_stride_q  <= read_stride_d;
            write_stride_q <= write_stride_d;
            fill_value_q   <= fill_value_d;
            fill_q         <= fill_d;
            aborted_q      <= aborted_d;
        end
    end

    stream_copier_address_stepper #(.addrBits(addrBits)) u_read_stepper (
        .clk       (clk),
        .reset     (reset),
        .load      (rd_load),
        .load_addr (startReadAddress),
        .step      (rd_step),
        .stride    (read_stride_q),
        .addr      (readAddress)
    );

    stream_copier_address_stepper #(.addrBits(addrBits)) u_write_stepper (
        .clk       (clk),
        .reset     (reset),
        .load      (wr_load),
        .load_addr (startWriteAddress),
        .step      (wr_step),
        .stride    (write_stride_q),
        .addr      (writeAddress)
    );

    assign busy               = (state_q == ST_PRIME) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign finished           = (state_q == ST_DONE);
    assign aborted            = aborted_q;
    assign readReadWriteMode  = 1'b0;
    assign writeReadWriteMode = wr_en;
    // Copy data comes straight from the source RAM output, which lags its address by one cycle.
    assign writeDataIn        = wr_en ? (fill_q ? fill_value_q : readDataOut) : '0;
    assign state_dbg          = state_q;

endmodule
